// File: rtl/harvard_prog_loader.sv
// Boot-time program loader: accepts a framed byte stream (length, payload,
// XOR checksum), writes whole instructions into imem, and holds the core in
// reset until the checksum has been verified.
module harvard_prog_loader #(
    parameter int INSTR_W    = 32,
    parameter int ADDR_W     = 8,
    parameter int RESET_HOLD = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_in_data,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [INSTR_W-1:0] o_imem_wdata,
    output logic               o_core_reset,
    output logic               o_load_done,
    output logic               o_load_err
);

    localparam int BYTES = INSTR_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int HC_W  = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    // Capacity in words; 17 bits so a 16-bit length can exceed it cleanly.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [15:0]         r_len;
    logic [7:0]          r_xor;
    logic [BC_W-1:0]     r_byte_cnt;
    logic [ADDR_W:0]     r_word_idx;   // one extra bit so N = 2**ADDR_W never wraps
    logic [HC_W-1:0]     r_hold_cnt;
    logic                r_in_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [INSTR_W-1:0]  r_imem_wdata;
    logic                r_core_reset;
    logic                r_load_done;
    logic                r_load_err;

    logic                w_xfer;
    logic [15:0]         w_len_full;
    logic                w_last_word;
    logic [INSTR_W-1:0]  w_wdata_next;

    assign w_xfer      = i_in_valid & r_in_ready;
    assign w_len_full  = {r_len[15:8], i_in_data};
    assign w_last_word = (17'(r_word_idx) + 17'd1) == {1'b0, r_len};

    // Payload bytes are shifted straight into the write-data register; the bus
    // is only meaningful while imem_we is high, which saves a separate word buffer.
    generate
        if (BYTES > 1) begin : g_shift
            assign w_wdata_next = {r_imem_wdata[INSTR_W-9:0], i_in_data};
        end else begin : g_single
            assign w_wdata_next = i_in_data;
        end
    endgenerate

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_core_reset = r_core_reset;
    assign o_load_done  = r_load_done;
    assign o_load_err   = r_load_err;

    // Frame-parsing FSM; every output is registered and updated alongside the state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_LEN_HI;
            r_len        <= '0;
            r_xor        <= '0;
            r_byte_cnt   <= '0;
            r_word_idx   <= '0;
            r_hold_cnt   <= '0;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_LEN_HI: begin
                    // ready rises here on the first clock out of reset
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_len[15:8] <= i_in_data;
                        r_xor       <= r_xor ^ i_in_data;
                        r_state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= i_in_data;
                        r_xor      <= r_xor ^ i_in_data;
                        if ({1'b0, w_len_full} > MAX_WORDS) begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_xor        <= r_xor ^ i_in_data;
                        r_imem_wdata <= w_wdata_next;
                        if (r_byte_cnt == BC_W'(BYTES - 1)) begin
                            r_byte_cnt  <= '0;
                            r_imem_we   <= 1'b1;
                            r_imem_addr <= r_word_idx[ADDR_W-1:0];
                            r_word_idx  <= r_word_idx + (ADDR_W+1)'(1);
                            if (w_last_word) begin
                                r_state <= S_CHK;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        end
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        r_hold_cnt <= '0;
                        if (i_in_data == r_xor) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // core stays in reset for RESET_HOLD cycles after a good checksum
                    if (r_hold_cnt == HC_W'(RESET_HOLD - 1)) begin
                        r_state      <= S_RUN;
                        r_core_reset <= 1'b0;
                        r_load_done  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    // unreachable encoding: fail safe with the core held in reset
                    r_state      <= S_ERR;
                    r_load_err   <= 1'b1;
                    r_in_ready   <= 1'b0;
                    r_core_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harvard_prog_loader.sv
// Scoreboard bench for harvard_prog_loader: expected imem writes are queued
// as frames are issued and a negedge monitor pops/compares each write.
module tb_harvard_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        o_in_ready;
    logic        o_imem_we;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_core_reset;
    logic        o_load_done;
    logic        o_load_err;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] frm[$];
    int         n_vec = 0;
    int         n_bad = 0;

    harvard_prog_loader #(.INSTR_W(32), .ADDR_W(8), .RESET_HOLD(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (o_in_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_core_reset (o_core_reset),
        .o_load_done  (o_load_done),
        .o_load_err   (o_load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && o_imem_we) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", o_imem_addr, o_imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (o_imem_addr !== e.addr || o_imem_wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL imem_write: got addr=%h data=%h, required addr=%h data=%h",
                             o_imem_addr, o_imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Present one byte after `gap` idle cycles; returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        guard = 0;
        while (!o_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got in_ready=0 for 50 cycles, required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Send frm[]; each completed word must strobe imem_we in the very next cycle.
    task automatic send_frame(input bit rand_gap);
        int n;
        int gap;
        n = (frm.size() >= 2) ? int'({frm[0], frm[1]}) : 0;
        for (int i = 0; i < frm.size(); i++) begin
            gap = rand_gap ? int'($urandom_range(0, 3)) : 0;
            send_byte(frm[i], gap);
            if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
                check("we_timing", {31'd0, o_imem_we}, 32'd1);
        end
    endtask

    task automatic apply_reset();
        check("pending_writes", sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_in_ready",   {31'd0, o_in_ready},   32'd0);
        check("rst_imem_we",    {31'd0, o_imem_we},    32'd0);
        check("rst_imem_addr",  {24'd0, o_imem_addr},  32'd0);
        check("rst_imem_wdata", o_imem_wdata,          32'd0);
        check("rst_core_reset", {31'd0, o_core_reset}, 32'd1);
        check("rst_load_done",  {31'd0, o_load_done},  32'd0);
        check("rst_load_err",   {31'd0, o_load_err},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, o_in_ready}, 32'd1);
    endtask

    // Called at the negedge right after the CHK transfer of a good frame.
    task automatic expect_release();
        check("hold_ready",      {31'd0, o_in_ready},   32'd0);
        check("hold_core_reset", {31'd0, o_core_reset}, 32'd1);
        check("hold_done",       {31'd0, o_load_done},  32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("release_timing", {31'd0, o_core_reset}, (i < 4) ? 32'd1 : 32'd0);
        end
        check("run_done",  {31'd0, o_load_done}, 32'd1);
        check("run_err",   {31'd0, o_load_err},  32'd0);
        check("run_ready", {31'd0, o_in_ready},  32'd0);
        repeat (3) @(negedge clk);
        check("run_sticky", {30'd0, o_load_done, o_core_reset}, 32'd2);
    endtask

    task automatic expect_error();
        check("err_flag",       {31'd0, o_load_err},   32'd1);
        check("err_core_reset", {31'd0, o_core_reset}, 32'd1);
        check("err_ready",      {31'd0, o_in_ready},   32'd0);
        repeat (3) @(negedge clk);
        check("err_sticky", {29'd0, o_load_err, o_core_reset, o_load_done}, 32'd6);
    endtask

    task automatic load_good_frame(input bit rand_gap);
        frm = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
        push_wr(8'h00, 32'h11223344);
        push_wr(8'h01, 32'hAABBCCDD);
        send_frame(rand_gap);
        expect_release();
    endtask

    initial begin
        // Scenario 1: two-word program, good checksum
        apply_reset();
        load_good_frame(1'b0);

        // Scenario 2: same payload, wrong checksum
        apply_reset();
        frm = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};
        push_wr(8'h00, 32'h11223344);
        push_wr(8'h01, 32'hAABBCCDD);
        send_frame(1'b0);
        expect_error();

        // Scenario 3: length 257 exceeds 256-word capacity
        apply_reset();
        frm = '{8'h01, 8'h01};
        send_frame(1'b0);
        expect_error();

        // Scenario 4a: empty program, good checksum
        apply_reset();
        frm = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        expect_release();

        // Scenario 4b: empty program, bad checksum
        apply_reset();
        frm = '{8'h00, 8'h00, 8'h01};
        send_frame(1'b0);
        expect_error();

        // Scenario 5: scenario 1 with random idle gaps between bytes
        apply_reset();
        load_good_frame(1'b1);

        // Scenario 6: reset mid-word, then a full load
        apply_reset();
        frm = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_frame(1'b0);
        apply_reset();
        load_good_frame(1'b0);

        check("final_pending_writes", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
